// File: rtl/rc_pulse_width_mc.sv
// Multi-channel RC/servo pulse-width meter: each channel synchronises its input,
// counts prescaled ticks while high and publishes the width on the falling edge.
module rc_pulse_width_mc #(
    parameter int CH    = 4,
    parameter int W     = 12,
    parameter int PRESC = 50,
    parameter int TMO   = 2500
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [CH-1:0]   pul_in,
    output logic [CH*W-1:0] d,
    output logic [CH-1:0]   valid,
    output logic [CH-1:0]   ovf,
    output logic [CH-1:0]   lost
);
    localparam int            PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [W-1:0]  MAX_CNT    = '1;
    localparam logic [W-1:0]  TMO_CNT    = W'(TMO);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    typedef enum logic {IDLE, HIGH} state_t;

    logic [CH-1:0] sync1;
    logic [CH-1:0] s;
    logic [CH-1:0] prev;
    logic [2:0]    warm;
    logic [PW-1:0] presc_cnt;
    logic          tick;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;

    state_t        state   [CH];
    logic [W-1:0]  temp    [CH];
    logic [W-1:0]  tmo_cnt [CH];
    logic [CH-1:0] sat;

    // NOTE: every clocked block uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            s     <= '0;
            prev  <= '0;
            warm  <= '0;
        end else begin
            sync1 <= pul_in;
            s     <= sync1;
            prev  <= s;
            warm  <= {warm[1:0], 1'b1};
        end
    end

    // Until the pipeline holds three real samples, a level already high at reset
    // release would look like a rise; those are suppressed so only full pulses count.
    assign rise = s & ~prev & {CH{warm[2]}};
    assign fall = ~s & prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (!en || presc_cnt == PRESC_LAST) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PW'(1);
        end
    end

    assign tick = en && (presc_cnt == PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these per-channel arrays are a few flops each, not RAM, so clearing every element on reset is intended.
            for (int i = 0; i < CH; i++) begin
                state[i]   <= IDLE;
                temp[i]    <= '0;
                tmo_cnt[i] <= '0;
            end
            sat   <= '0;
            d     <= '0;
            valid <= '0;
            ovf   <= '0;
            lost  <= '0;
        end else if (!en) begin
            for (int i = 0; i < CH; i++) begin
                state[i]   <= IDLE;
                temp[i]    <= '0;
                tmo_cnt[i] <= '0;
            end
            sat   <= '0;
            valid <= '0;
            lost  <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                valid[i] <= 1'b0;

                if (rise[i]) begin
                    tmo_cnt[i] <= '0;
                end else if (tick && tmo_cnt[i] != TMO_CNT) begin
                    tmo_cnt[i] <= tmo_cnt[i] + W'(1);
                    if (tmo_cnt[i] == TMO_CNT - W'(1)) begin
                        lost[i] <= 1'b1;
                    end
                end

                // A publish clears lost after the timeout update so it wins a same-cycle tie.
                case (state[i])
                    IDLE: begin
                        if (rise[i]) begin
                            state[i] <= HIGH;
                            temp[i]  <= '0;
                            sat[i]   <= 1'b0;
                        end
                    end
                    HIGH: begin
                        if (fall[i]) begin
                            d[i*W +: W] <= temp[i];
                            ovf[i]      <= sat[i];
                            valid[i]    <= 1'b1;
                            lost[i]     <= 1'b0;
                            state[i]    <= IDLE;
                        end else if (tick && s[i] && !rise[i]) begin
                            if (temp[i] == MAX_CNT) begin
                                sat[i] <= 1'b1;
                            end else begin
                                temp[i] <= temp[i] + W'(1);
                            end
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

endmodule
